// File: rtl/idex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, memory-busy hold and branch flush.
// Tracks the reason for each cycle's action and keeps saturating bubble/hold counters.
module idex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_IFID,
  input  logic [4:0]        rs_IFID,
  input  logic [4:0]        rt_IFID,
  input  logic [4:0]        rd_IFID,
  input  logic [DATA_W-1:0] readData1_ID,
  input  logic [DATA_W-1:0] readData2_ID,
  input  logic [DATA_W-1:0] imm_ID,
  input  logic [DATA_W-1:0] pc_ID,
  input  logic              regWrite_ID,
  input  logic              memRead_ID,
  input  logic              memWrite_ID,
  input  logic              memToReg_ID,
  input  logic              aluSrc_ID,
  input  logic [3:0]        aluOp_ID,
  input  logic              flush,
  input  logic              memBusy,
  output logic              valid_IDEX,
  output logic [4:0]        rs_IDEX,
  output logic [4:0]        rt_IDEX,
  output logic [4:0]        rd_IDEX,
  output logic [DATA_W-1:0] readData1_IDEX,
  output logic [DATA_W-1:0] readData2_IDEX,
  output logic [DATA_W-1:0] imm_IDEX,
  output logic [DATA_W-1:0] pc_IDEX,
  output logic              regWrite_IDEX,
  output logic              memRead_IDEX,
  output logic              memWrite_IDEX,
  output logic              memToReg_IDEX,
  output logic              aluSrc_IDEX,
  output logic [3:0]        aluOp_IDEX,
  output logic              stall_IFID,
  output logic [1:0]        hazState,
  output logic [CNT_W-1:0]  bubbleCount,
  output logic [CNT_W-1:0]  holdCount
);

  typedef enum logic [1:0] {
    RUN       = 2'b00,
    LU_BUBBLE = 2'b01,
    MEM_HOLD  = 2'b10,
    FLUSHED   = 2'b11
  } haz_e;

  typedef struct packed {
    logic              valid;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              alu_src;
    logic [3:0]        alu_op;
  } idex_t;

  idex_t            stage_q;
  idex_t            capture;
  haz_e             haz_q;
  logic             load_use;

  // Control bits of an empty decode slot are dropped so no write enable is ever latched.
  always_comb begin
    capture            = '0;
    capture.valid      = valid_IFID;
    capture.rs         = rs_IFID;
    capture.rt         = rt_IFID;
    capture.rd         = rd_IFID;
    capture.data1      = readData1_ID;
    capture.data2      = readData2_ID;
    capture.imm        = imm_ID;
    capture.pc         = pc_ID;
    capture.reg_write  = valid_IFID & regWrite_ID;
    capture.mem_read   = valid_IFID & memRead_ID;
    capture.mem_write  = valid_IFID & memWrite_ID;
    capture.mem_to_reg = valid_IFID & memToReg_ID;
    capture.alu_src    = valid_IFID & aluSrc_ID;
    capture.alu_op     = valid_IFID ? aluOp_ID : 4'd0;
  end

  assign load_use = stage_q.valid & stage_q.mem_read & (stage_q.rd != 5'd0) & valid_IFID &
                    ((stage_q.rd == rs_IFID) | (stage_q.rd == rt_IFID));

  assign stall_IFID = memBusy | (load_use & ~flush);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q     <= '0;
      haz_q       <= RUN;
      bubbleCount <= '0;
      holdCount   <= '0;
    end else if (memBusy) begin
      haz_q <= MEM_HOLD;
      if (holdCount != '1) holdCount <= holdCount + 1'b1;
    end else if (flush) begin
      stage_q <= '0;
      haz_q   <= FLUSHED;
    end else if (load_use) begin
      stage_q <= '0;
      haz_q   <= LU_BUBBLE;
      if (bubbleCount != '1) bubbleCount <= bubbleCount + 1'b1;
    end else begin
      stage_q <= capture;
      haz_q   <= RUN;
    end
  end

  assign valid_IDEX     = stage_q.valid;
  assign rs_IDEX        = stage_q.rs;
  assign rt_IDEX        = stage_q.rt;
  assign rd_IDEX        = stage_q.rd;
  assign readData1_IDEX = stage_q.data1;
  assign readData2_IDEX = stage_q.data2;
  assign imm_IDEX       = stage_q.imm;
  assign pc_IDEX        = stage_q.pc;
  assign regWrite_IDEX  = stage_q.reg_write;
  assign memRead_IDEX   = stage_q.mem_read;
  assign memWrite_IDEX  = stage_q.mem_write;
  assign memToReg_IDEX  = stage_q.mem_to_reg;
  assign aluSrc_IDEX    = stage_q.alu_src;
  assign aluOp_IDEX     = stage_q.alu_op;
  assign hazState       = haz_q;

endmodule
